gate_truth_checker: RTL
=======================

# gate_truth_checker

Synchronous exhaustive truth-table checker for small combinational gates built from switch-level CMOS primitives (NAND3, NOR3, and similar). It drives every input vector onto the gate under test and waits a programmable settle time. It then samples the gate output, compares it against a parameterised truth table, and reports the error count, the first failing vector and a pass flag. It sits in the gate-level benches as the stimulus/response end facing each CMOS gate model.

## Interface
Parameters:
- N_IN, 3: gate input count; 1..6.
- TRUTH, 8'h7F: expected output, bit i is the expected output for input vector i. Width 2**N_IN. The default is NAND3.
- SETTLE, 2: idle cycles per vector before sampling; 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- stim  out  N_IN  registered vector driven to gate inputs (bit 0 = first input, A).
- resp  in  1  gate output F.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  high when the last run had zero mismatches; held until the next start or rst.
- err_count  out  N_IN+1  mismatches in the current/last run; saturation impossible.
- fail_seen  out  1  at least one mismatch this run.
- first_fail  out  N_IN  vector of the first mismatch; valid when fail_seen=1.

## Operation
- FSM states are IDLE, APPLY, CHECK, FIN.
- IDLE: stim=0, busy=0. If start=1, go to APPLY. In the same transition, clear err_count, fail_seen, first_fail and pass, and load the vector counter with 0.
- APPLY: stim holds the current vector. A wait counter counts SETTLE cycles, then the FSM goes to CHECK. If SETTLE=0, APPLY lasts 0 cycles and the FSM enters CHECK directly from IDLE or from the previous CHECK.
- CHECK, one cycle: compare resp against TRUTH[stim] using four-state equality, so X/Z on resp counts as a mismatch.
  - On mismatch, increment err_count. If fail_seen=0, set fail_seen and capture first_fail=stim.
  - If stim is the last vector (2**N_IN-1), go to FIN. Otherwise increment stim and go to APPLY.
- FIN, one cycle: done=1, busy=0, and pass is set to (err_count==0), including any mismatch from the final CHECK. Then go to IDLE; stim returns to 0.
- start is ignored outside IDLE. A start held high continuously produces back-to-back runs, each restarting from IDLE.
- rst at any cycle, including mid-run, forces state to IDLE.

## Timing
- Reset values: stim=0, busy=0, done=0, pass=0, err_count=0, fail_seen=0, first_fail=0.
- Start is sampled at edge 0. At edge 1 stim=0 and busy=1.
- Each vector occupies SETTLE+1 cycles. resp is sampled in the last cycle of the vector, before stim advances.
- done is high in the cycle starting at edge 1 + 2**N_IN*(SETTLE+1). For the defaults (N_IN=3, SETTLE=2) that is edge 25.
- Consecutive runs: the earliest next start is sampled in the IDLE cycle after FIN, so there are 2 cycles of gap between runs.
- err_count, fail_seen and first_fail update at the edge ending CHECK and stay stable through FIN and IDLE.

## Structure
- Package gate_check_pkg holds:
  - the FSM state enum;
  - truth-table constants TT_NAND3=8'h7F, TT_NOR3=8'h01, TT_AND3=8'h80, TT_OR3=8'hFE, TT_NAND2=4'h7;
  - the SETTLE default.
- One sub-module, gate_vec_seq, holds the vector counter and the settle wait counter. It outputs stim, last_vec and settle_done. The top holds the FSM and the result registers.

## Test plan
- NAND3 switch-level gate, defaults, start pulsed at edge 0:
  - done at edge 25, pass=1, err_count=0, fail_seen=0;
  - stim walks 0..7, each value held 3 cycles.
- Same gate with TRUTH=8'hFF (deliberately wrong): err_count=1, fail_seen=1, first_fail=3'b111, pass=0.
- resp tied to 0, TRUTH=8'h7F: err_count=7, first_fail=3'b000, pass=0.
- resp driven Z (gate disconnected): err_count=8, first_fail=0, pass=0.
- rst asserted at edge 10 mid-run:
  - next cycle all outputs are at reset values;
  - a new start completes normally with pass=1.
- SETTLE=0 with a NOR3 gate and TRUTH=8'h01: done at edge 9, pass=1. A start held high gives the next busy=1 at edge 11.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the exhaustive gate truth-table checker.
// FSM state encoding, common gate truth tables and the default settle time.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Bit i is the expected gate output for input vector i.
  localparam logic [7:0] TT_NAND3 = 8'h7F;
  localparam logic [7:0] TT_NOR3  = 8'h01;
  localparam logic [7:0] TT_AND3  = 8'h80;
  localparam logic [7:0] TT_OR3   = 8'hFE;
  localparam logic [3:0] TT_NAND2 = 4'h7;

  localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/gate_vec_seq.sv
// Vector counter and settle wait counter; stim advances only on request.
// Zero latency on stim/last_vec, settle_done is combinational from the wait count.
module gate_vec_seq #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            advance,
  input  logic            wait_en,
  output logic [N_IN-1:0] stim,
  output logic            last_vec,
  output logic            settle_done
);

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

  logic [3:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stim <= '0;
    end else if (advance) begin
      stim <= stim + N_IN'(1);
    end
  end

  // Wait count restarts every time the APPLY phase is left.
  always_ff @(posedge clk) begin
    if (rst || !wait_en) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign last_vec    = (stim == {N_IN{1'b1}});
  assign settle_done = (wait_cnt == SETTLE_LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// Walks every input vector through a gate, waits SETTLE cycles, compares resp to TRUTH.
// Run length 2**N_IN*(SETTLE+1) cycles plus FIN; start is only honoured in IDLE.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                    N_IN   = 3,
  parameter logic [2**N_IN-1:0]    TRUTH  = TT_NAND3,
  parameter int                    SETTLE = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail
);

  // With no settle time each vector is a single CHECK cycle.
  localparam state_t ST_VEC = (SETTLE == 0) ? ST_CHECK : ST_APPLY;

  state_t state, state_nxt;
  logic   last_vec, settle_done, mismatch;

  gate_vec_seq #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .clear       ((state == ST_IDLE) || (state == ST_FIN)),
    .advance     ((state == ST_CHECK) && !last_vec),
    .wait_en     (state == ST_APPLY),
    .stim        (stim),
    .last_vec    (last_vec),
    .settle_done (settle_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_VEC;
      ST_APPLY: if (settle_done) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = last_vec ? ST_FIN : ST_VEC;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_APPLY) || (state == ST_CHECK);
    done = (state == ST_FIN);
  end

  // Case inequality so an undriven or unknown gate output is never a match.
  assign mismatch = (resp !== TRUTH[stim]);

  always_ff @(posedge clk) begin
    if (rst) begin
      pass       <= 1'b0;
      err_count  <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else if ((state == ST_IDLE) && start) begin
      pass       <= 1'b0;
      err_count  <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else if ((state == ST_CHECK) && mismatch) begin
      err_count <= err_count + (N_IN+1)'(1);
      if (!fail_seen) begin
        fail_seen  <= 1'b1;
        first_fail <= stim;
      end
    end else if (state == ST_FIN) begin
      pass <= (err_count == '0);
    end
  end

endmodule
